dcache_snoop_responder: RTL



---
 rtl/cpu_types_pkg.sv | 27 ++
 rtl/snoop_tag_match.sv | 28 ++
 rtl/dcache_snoop_responder.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared dcache address/word types and snoop FSM state encoding
package cpu_types_pkg;

  localparam int WORD_W = 32;
  localparam int DTAG_W = 26;
  localparam int DIDX_W = 3;
  localparam int DBLK_W = 1;
  localparam int DBYT_W = 2;

  typedef logic [WORD_W-1:0] word_t;

  typedef struct packed {
    logic [DTAG_W-1:0] tag;
    logic [DIDX_W-1:0] idx;
    logic [DBLK_W-1:0] blkoff;
    logic [DBYT_W-1:0] bytoff;
  } dcachef_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOOKUP  = 3'd1,
    SUPPLY0 = 3'd2,
    SUPPLY1 = 3'd3,
    UPDATE  = 3'd4
  } snoop_state_t;

endpackage

// File: rtl/snoop_tag_match.sv
// rtl/snoop_tag_match.sv - combinational 2-way tag compare; way 0 has priority on a double hit
module snoop_tag_match
  import cpu_types_pkg::*;
#(
  parameter int TAG_W = DTAG_W
) (
  input  logic [TAG_W-1:0]      tag,
  input  logic [1:0][TAG_W-1:0] tag_rd,
  input  logic [1:0]            valid_rd,
  input  logic [1:0]            dirty_rd,
  output logic                  hit,
  output logic                  hit_way,
  output logic                  hit_dirty,
  output logic                  multi_hit
);

  logic [1:0] way_hit;

  always_comb begin
    way_hit[0] = valid_rd[0] && (tag_rd[0] == tag);
    way_hit[1] = valid_rd[1] && (tag_rd[1] == tag);
    hit        = |way_hit;
    multi_hit  = &way_hit;
    hit_way    = !way_hit[0] && way_hit[1];
    hit_dirty  = hit && dirty_rd[hit_way];
  end

endmodule

// File: rtl/dcache_snoop_responder.sv
// rtl/dcache_snoop_responder.sv - dcache-side snoop lookup, M-block supply and frame downgrade
// Optional SNOOP_STATS_EN adds saturating snoop_hits / snoop_invals counters.
module dcache_snoop_responder
  import cpu_types_pkg::*;
#(
  parameter int TAG_W = DTAG_W,
  parameter int IDX_W = DIDX_W
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  ccwait,
  input  logic                  ccinv,
  input  word_t                 ccsnoopaddr,
  input  logic                  dwait,
  input  logic [1:0][TAG_W-1:0] tag_rd,
  input  logic [1:0]            valid_rd,
  input  logic [1:0]            dirty_rd,
  input  word_t                 snp_rdata,
  output logic [IDX_W-1:0]      snp_idx,
  output logic                  snp_way,
  output logic                  snp_blkoff,
  output logic                  ccwrite,
  output word_t                 dstore,
  output logic                  upd_en,
  output logic                  upd_valid,
  output logic                  upd_dirty,
  output logic                  snoop_busy
`ifdef SNOOP_STATS_EN
  ,
  output logic [31:0]           snoop_hits,
  output logic [31:0]           snoop_invals
`endif
);

  snoop_state_t state, state_n;
  word_t        snp_addr;
  logic         snp_inv;
  logic         hit_way_q, hit_dirty_q;
  logic         rearm_wait, rearm_wait_n;
  logic         hit, hit_way, hit_dirty, multi_hit;
  logic [TAG_W-1:0] snp_tag;
  logic         addr_unused;

  assign snp_tag     = snp_addr[31 -: TAG_W];
  assign snp_idx     = snp_addr[3 +: IDX_W];
  assign addr_unused = ^snp_addr[2:0];

  snoop_tag_match #(.TAG_W(TAG_W)) u_tag_match (
    .tag       (snp_tag),
    .tag_rd    (tag_rd),
    .valid_rd  (valid_rd),
    .dirty_rd  (dirty_rd),
    .hit       (hit),
    .hit_way   (hit_way),
    .hit_dirty (hit_dirty),
    .multi_hit (multi_hit)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= IDLE;
      snp_addr    <= '0;
      snp_inv     <= 1'b0;
      hit_way_q   <= 1'b0;
      hit_dirty_q <= 1'b0;
      rearm_wait  <= 1'b0;
    end else begin
      state      <= state_n;
      rearm_wait <= rearm_wait_n;
      if (state == IDLE && state_n == LOOKUP) begin
        snp_addr <= ccsnoopaddr;
        snp_inv  <= ccinv;
      end
      if (state == LOOKUP) begin
        hit_way_q   <= hit_way;
        hit_dirty_q <= hit_dirty;
      end
    end
  end

  // rearm_wait blocks a still-held ccwait from replaying a finished snoop
  always_comb begin
    state_n      = state;
    rearm_wait_n = rearm_wait;
    case (state)
      IDLE: begin
        if (!ccwait)          rearm_wait_n = 1'b0;
        else if (!rearm_wait) state_n      = LOOKUP;
      end
      LOOKUP: begin
        if (!ccwait)                state_n = IDLE;
        else if (hit && hit_dirty)  state_n = SUPPLY0;
        else if (hit && snp_inv)    state_n = UPDATE;
        else begin
          state_n      = IDLE;
          rearm_wait_n = 1'b1;
        end
      end
      SUPPLY0: begin
        if (!ccwait)     state_n = IDLE;
        else if (!dwait) state_n = SUPPLY1;
      end
      SUPPLY1: begin
        if (!ccwait)     state_n = IDLE;
        else if (!dwait) state_n = UPDATE;
      end
      UPDATE: begin
        state_n      = IDLE;
        rearm_wait_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  assign snoop_busy = (state != IDLE);
  assign ccwrite    = (state == SUPPLY0 || state == SUPPLY1) && hit_dirty_q;
  assign snp_blkoff = (state == SUPPLY1);
  assign snp_way    = hit_way_q;
  assign dstore     = ccwrite ? snp_rdata : '0;
  assign upd_en     = (state == UPDATE);
  // the bus writes memory back during the transfer, so a surviving frame is always clean
  assign upd_valid  = upd_en && !snp_inv;
  assign upd_dirty  = 1'b0;

`ifdef SNOOP_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      snoop_hits   <= '0;
      snoop_invals <= '0;
    end else begin
      if (state == LOOKUP && ccwait && hit && snoop_hits != '1)
        snoop_hits <= snoop_hits + 32'd1;
      if (state == UPDATE && snp_inv && snoop_invals != '1)
        snoop_invals <= snoop_invals + 32'd1;
    end
  end
`endif

  a_no_dual_hit: assert property (@(posedge CLK) disable iff (!nRST)
    (state == LOOKUP) |-> !multi_hit);

endmodule
